// File: rtl/trafficlight_pkg.sv
// Shared phase encodings and lamp bit positions for the two-road traffic controller.
package trafficlight_pkg;

    typedef enum logic [2:0] {
        S_AG = 3'b000,
        S_AY = 3'b001,
        S_BG = 3'b010,
        S_BY = 3'b011,
        S_FL = 3'b100
    } phase_t;

    localparam int A_RED = 5;
    localparam int A_YEL = 4;
    localparam int A_GRN = 3;
    localparam int B_RED = 2;
    localparam int B_YEL = 1;
    localparam int B_GRN = 0;

endpackage

// File: rtl/trafficlight_ctrl_param_if.sv
// Sensor/maintenance inputs and lamp/countdown outputs of the traffic controller.
interface trafficlight_ctrl_param_if #(parameter int TW = 6);
    logic          AS;
    logic          BS;
    logic          FLASH;
    logic [2:0]    state;
    logic [TW-1:0] A_time;
    logic [TW-1:0] B_time;
    logic [5:0]    led;

    modport master (output AS, BS, FLASH, input state, A_time, B_time, led);
    modport slave  (input AS, BS, FLASH, output state, A_time, B_time, led);
endinterface

// File: rtl/tick_prescaler.sv
// Free-running clock divider producing a one-cycle tick every TICK_DIV clocks.
module tick_prescaler #(
    parameter int TICK_DIV = 1
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic clr,
    output logic tick
);
    localparam int PW = $clog2(TICK_DIV) + 1;
    localparam logic [PW-1:0] LAST_C = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_r;

    assign tick = (pre_r == LAST_C);

    // Prescaler counter: wraps after the tick cycle, cleared on demand.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            pre_r <= '0;
        end else if (clr || tick) begin
            pre_r <= '0;
        end else begin
            pre_r <= pre_r + 1'b1;
        end
    end
endmodule

// File: rtl/trafficlight_ctrl_param.sv
// Two-road traffic light FSM with gap-out, countdown outputs and flashing maintenance mode.
module trafficlight_ctrl_param
    import trafficlight_pkg::*;
#(
    parameter int TW        = 6,
    parameter int TICK_DIV  = 1,
    parameter int A_GREEN   = 25,
    parameter int B_GREEN   = 15,
    parameter int YELLOW    = 5,
    parameter int MIN_GREEN = 3
) (
    input logic                     CLK,
    input logic                     RSTn,
    trafficlight_ctrl_param_if.slave bus
);
    localparam int MAX_GREEN = (A_GREEN > B_GREEN) ? A_GREEN : B_GREEN;

    if (MAX_GREEN + YELLOW >= (1 << TW)) begin : g_cfg_check
        $error("trafficlight_ctrl_param: green + yellow does not fit in TW bits");
    end

    localparam logic [TW-1:0] A_GREEN_C = TW'(A_GREEN);
    localparam logic [TW-1:0] B_GREEN_C = TW'(B_GREEN);
    localparam logic [TW-1:0] YELLOW_C  = TW'(YELLOW);
    localparam logic [TW-1:0] MIN_GRN_C = TW'(MIN_GREEN);
    localparam logic [TW-1:0] ONE_C     = TW'(1);

    phase_t        state_r, state_n_s;
    logic [TW-1:0] cnt_r, cnt_n_s;
    logic          flash_r, flash_n_s;
    logic          tick_s, clr_s;
    logic          last_s, a_gap_s, b_gap_s;
    logic [TW-1:0] a_time_s, b_time_s;
    logic [5:0]    led_s;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .CLK  (CLK),
        .RSTn (RSTn),
        .clr  (clr_s),
        .tick (tick_s)
    );

    // Elapsed green ticks include the current one, hence the +1.
    assign last_s  = (cnt_r == ONE_C);
    assign a_gap_s = ((A_GREEN_C - cnt_r + ONE_C) >= MIN_GRN_C) && !bus.AS && bus.BS;
    assign b_gap_s = ((B_GREEN_C - cnt_r + ONE_C) >= MIN_GRN_C) && !bus.BS && bus.AS;

    // Next-state, countdown reload and flash-phase logic.
    always_comb begin
        state_n_s = state_r;
        cnt_n_s   = cnt_r;
        flash_n_s = flash_r;
        clr_s     = 1'b0;
        if (bus.FLASH) begin
            state_n_s = S_FL;
            cnt_n_s   = '0;
            if (state_r != S_FL) begin
                flash_n_s = 1'b1;
            end else if (tick_s) begin
                flash_n_s = ~flash_r;
            end else begin
                flash_n_s = flash_r;
            end
        end else begin
            case (state_r)
                S_AG: begin
                    if (tick_s && ((last_s && bus.BS) || a_gap_s)) begin
                        state_n_s = S_AY;
                        cnt_n_s   = YELLOW_C;
                    end else if (tick_s) begin
                        cnt_n_s = last_s ? A_GREEN_C : cnt_r - ONE_C;
                    end else begin
                        cnt_n_s = cnt_r;
                    end
                end
                S_AY: begin
                    if (tick_s && last_s) begin
                        state_n_s = S_BG;
                        cnt_n_s   = B_GREEN_C;
                    end else if (tick_s) begin
                        cnt_n_s = cnt_r - ONE_C;
                    end else begin
                        cnt_n_s = cnt_r;
                    end
                end
                S_BG: begin
                    if (tick_s && ((last_s && bus.AS) || b_gap_s)) begin
                        state_n_s = S_BY;
                        cnt_n_s   = YELLOW_C;
                    end else if (tick_s) begin
                        cnt_n_s = last_s ? B_GREEN_C : cnt_r - ONE_C;
                    end else begin
                        cnt_n_s = cnt_r;
                    end
                end
                S_BY: begin
                    if (tick_s && last_s) begin
                        state_n_s = S_AG;
                        cnt_n_s   = A_GREEN_C;
                    end else if (tick_s) begin
                        cnt_n_s = cnt_r - ONE_C;
                    end else begin
                        cnt_n_s = cnt_r;
                    end
                end
                default: begin
                    state_n_s = S_AG;
                    cnt_n_s   = A_GREEN_C;
                    flash_n_s = 1'b0;
                    clr_s     = 1'b1;
                end
            endcase
        end
    end

    // State, countdown and flash-phase registers.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_r <= S_AG;
            cnt_r   <= A_GREEN_C;
            flash_r <= 1'b0;
        end else begin
            state_r <= state_n_s;
            cnt_r   <= cnt_n_s;
            flash_r <= flash_n_s;
        end
    end

    // Countdown displays and lamp decode from the current phase.
    always_comb begin
        a_time_s = cnt_r;
        b_time_s = cnt_r;
        led_s    = '0;
        case (state_r)
            S_AG: begin
                b_time_s     = cnt_r + YELLOW_C;
                led_s[A_GRN] = 1'b1;
                led_s[B_RED] = 1'b1;
            end
            S_AY: begin
                led_s[A_YEL] = 1'b1;
                led_s[B_RED] = 1'b1;
            end
            S_BG: begin
                a_time_s     = cnt_r + YELLOW_C;
                led_s[A_RED] = 1'b1;
                led_s[B_GRN] = 1'b1;
            end
            S_BY: begin
                led_s[A_RED] = 1'b1;
                led_s[B_YEL] = 1'b1;
            end
            default: begin
                a_time_s     = '0;
                b_time_s     = '0;
                led_s[A_YEL] = flash_r;
                led_s[B_YEL] = flash_r;
            end
        endcase
    end

    assign bus.state  = state_r;
    assign bus.A_time = a_time_s;
    assign bus.B_time = b_time_s;
    assign bus.led    = led_s;
endmodule

// File: tb/tb_trafficlight_ctrl_param.sv
// Directed-vector bench: one controller with TICK_DIV=1, a second with TICK_DIV=4.
module tb_trafficlight_ctrl_param;
    logic clk = 1'b0;
    logic rstn1;
    logic rstn4;
    int   total_cnt = 0;
    int   bad_cnt   = 0;

    always #5 clk = ~clk;

    trafficlight_ctrl_param_if #(.TW(6)) b1 ();
    trafficlight_ctrl_param_if #(.TW(6)) b4 ();

    trafficlight_ctrl_param #(
        .TW(6), .TICK_DIV(1), .A_GREEN(8), .B_GREEN(6), .YELLOW(2), .MIN_GREEN(3)
    ) u_dut1 (.CLK(clk), .RSTn(rstn1), .bus(b1));

    trafficlight_ctrl_param #(
        .TW(6), .TICK_DIV(4), .A_GREEN(8), .B_GREEN(6), .YELLOW(2), .MIN_GREEN(3)
    ) u_dut4 (.CLK(clk), .RSTn(rstn4), .bus(b4));

    task automatic check_val(input string tag, input int obs, input int exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input int st, input int at, input int bt, input int ld);
        check_val({tag, " state"}, int'(b1.state), st);
        check_val({tag, " A_time"}, int'(b1.A_time), at);
        check_val({tag, " B_time"}, int'(b1.B_time), bt);
        check_val({tag, " led"}, int'(b1.led), ld);
    endtask

    initial begin
        int c;
        rstn1 = 1'b0;
        rstn4 = 1'b0;
        b1.AS = 1'b1; b1.BS = 1'b1; b1.FLASH = 1'b0;
        b4.AS = 1'b1; b4.BS = 1'b1; b4.FLASH = 1'b0;
        step();
        step();
        check1("reset", 0, 8, 10, 6'b001100);

        // Test 1: full cycle with demand on both roads
        rstn1 = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            step();
            if (k < 8)
                check1($sformatf("t1 k=%0d", k), 0, 8 - k, 10 - k, 6'b001100);
            else if (k < 10)
                check1($sformatf("t1 k=%0d", k), 1, 10 - k, 10 - k, 6'b010100);
            else if (k < 16)
                check1($sformatf("t1 k=%0d", k), 2, 18 - k, 16 - k, 6'b100001);
            else if (k < 18)
                check1($sformatf("t1 k=%0d", k), 3, 18 - k, 18 - k, 6'b100010);
            else
                check1($sformatf("t1 k=%0d", k), 0, 8, 10, 6'b001100);
        end

        // Test 2: no demand on B keeps A green with reloads
        b1.BS = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            step();
            c = 8 - (j % 8);
            check1($sformatf("t2 j=%0d", j), 0, c, c + 2, 6'b001100);
        end

        // Test 3: gap-out on A after minimum green
        rstn1 = 1'b0; b1.AS = 1'b0; b1.BS = 1'b1;
        step();
        check1("t3 reset", 0, 8, 10, 6'b001100);
        rstn1 = 1'b1;
        step(); check1("t3 e1", 0, 7, 9, 6'b001100);
        step(); check1("t3 e2", 0, 6, 8, 6'b001100);
        step(); check1("t3 e3", 1, 2, 2, 6'b010100);
        step(); check1("t3 e4", 1, 1, 1, 6'b010100);
        step(); check1("t3 e5", 2, 8, 6, 6'b100001);

        // Test 4: flash mode entry, toggling and exit
        b1.FLASH = 1'b1;
        step(); check1("t4 f1", 4, 0, 0, 6'b010010);
        step(); check1("t4 f2", 4, 0, 0, 6'b000000);
        step(); check1("t4 f3", 4, 0, 0, 6'b010010);
        step(); check1("t4 f4", 4, 0, 0, 6'b000000);
        b1.FLASH = 1'b0;
        step(); check1("t4 exit", 0, 8, 10, 6'b001100);
        step(); check1("t4 post", 0, 7, 9, 6'b001100);

        // Test 5: reset in S_BY overrides FLASH
        rstn1 = 1'b0; b1.AS = 1'b1; b1.BS = 1'b1;
        step();
        rstn1 = 1'b1;
        for (int k = 1; k <= 16; k++) step();
        check1("t5 in BY", 3, 2, 2, 6'b100010);
        rstn1 = 1'b0; b1.FLASH = 1'b1;
        step();
        check1("t5 reset", 0, 8, 10, 6'b001100);
        rstn1 = 1'b1; b1.FLASH = 1'b0;

        // Test 6: prescaled controller runs four times slower
        check_val("t6 reset A_time", int'(b4.A_time), 8);
        rstn4 = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            step();
            if (k < 32) begin
                check_val($sformatf("t6 k=%0d state", k), int'(b4.state), 0);
                check_val($sformatf("t6 k=%0d A_time", k), int'(b4.A_time), 8 - k / 4);
            end else begin
                check_val($sformatf("t6 k=%0d state", k), int'(b4.state), 1);
                check_val($sformatf("t6 k=%0d A_time", k), int'(b4.A_time), 2);
            end
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
